// File: rtl/fft_pkg.sv
// Shared types and helpers for the iterative radix-2 IFFT.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DUMP = 2'd3
  } state_t;

  // Twiddles carry a sign bit and one integer bit; the rest are fraction bits.
  localparam int TW_INT_BITS = 2;

  function automatic int unsigned bitrev(input int unsigned x, input int unsigned bits);
    int unsigned r;
    r = 0;
    for (int unsigned b = 0; b < bits; b++) begin
      r = (r << 1) | ((x >> b) & 32'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/ifft_butterfly.sv
// Combinational radix-2 DIT butterfly: x = a + b*w, y = a - b*w.
// With IFFT_SCALE_EN defined each output is halved; both paths saturate to DATA_WIDTH.
module ifft_butterfly
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 20,
  parameter int TW_WIDTH   = 16
) (
  input  logic signed [DATA_WIDTH-1:0] a_r,
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] b_r,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  input  logic signed [TW_WIDTH-1:0]   w_r,
  input  logic signed [TW_WIDTH-1:0]   w_i,
  output logic signed [DATA_WIDTH-1:0] x_r,
  output logic signed [DATA_WIDTH-1:0] x_i,
  output logic signed [DATA_WIDTH-1:0] y_r,
  output logic signed [DATA_WIDTH-1:0] y_i
);

  localparam int PW   = DATA_WIDTH + TW_WIDTH + 1;
  localparam int FRAC = TW_WIDTH - TW_INT_BITS;
  localparam logic signed [PW-1:0] MAX_V = {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] MIN_V = ~MAX_V;

  function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [PW-1:0] v);
    if (v > MAX_V) return MAX_V[DATA_WIDTH-1:0];
    if (v < MIN_V) return MIN_V[DATA_WIDTH-1:0];
    return v[DATA_WIDTH-1:0];
  endfunction

  logic signed [PW-1:0] ar, ai, br, bi, wr, wi, p_r, p_i, s0_r, s0_i, s1_r, s1_i;

  always_comb begin
    ar   = PW'(a_r);
    ai   = PW'(a_i);
    br   = PW'(b_r);
    bi   = PW'(b_i);
    wr   = PW'(w_r);
    wi   = PW'(w_i);
    p_r  = (br * wr - bi * wi) >>> FRAC;
    p_i  = (br * wi + bi * wr) >>> FRAC;
    s0_r = ar + p_r;
    s0_i = ai + p_i;
    s1_r = ar - p_r;
    s1_i = ai - p_i;
`ifdef IFFT_SCALE_EN
    s0_r = s0_r >>> 1;
    s0_i = s0_i >>> 1;
    s1_r = s1_r >>> 1;
    s1_i = s1_i >>> 1;
`endif
    x_r = sat(s0_r);
    x_i = sat(s0_i);
    y_r = sat(s1_r);
    y_i = sat(s1_i);
  end

endmodule

// File: rtl/ifft_r2_dit_iter.sv
// Iterative in-place radix-2 DIT IFFT, one butterfly per cycle, N = 2**POW points.
// Define IFFT_SCALE_EN for a 1/N scaled result; otherwise write-backs saturate unscaled.
//
// state | meaning
// IDLE  | waiting for valid_in; first sample written on acceptance
// LOAD  | remaining N-1 samples written in bit-reversed order
// CALC  | POW*N/2 butterflies, stage by stage
// DUMP  | memory streamed out in natural order
module ifft_r2_dit_iter
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 20,
  parameter int POW        = 4,
  parameter int TW_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] sink_r,
  input  logic signed [DATA_WIDTH-1:0] sink_i,
  output logic                         busy,
  output logic                         valid_out,
  output logic signed [DATA_WIDTH-1:0] source_r,
  output logic signed [DATA_WIDTH-1:0] source_i
);

  localparam int N    = 1 << POW;
  localparam int FRAC = TW_WIDTH - TW_INT_BITS;
  localparam int SW   = (POW > 1) ? $clog2(POW) : 1;
  localparam int JW   = POW - 1;
  localparam logic [POW-1:0] ONE = POW'(1);
  localparam real PI_R = 3.141592653589793;

  state_t          state, state_nx;
  logic [POW-1:0]  cnt, load_addr;
  logic [JW-1:0]   bf, k_idx;
  logic [SW-1:0]   stage;
  logic            accept, cnt_last, bf_last;
  logic [POW-1:0]  bf_ext, span_bit, pos, a_idx, b_idx;

  logic signed [DATA_WIDTH-1:0] mem_r [N];
  logic signed [DATA_WIDTH-1:0] mem_i [N];
  logic signed [TW_WIDTH-1:0]   tw_r [N/2];
  logic signed [TW_WIDTH-1:0]   tw_i [N/2];
  logic signed [DATA_WIDTH-1:0] x_r, x_i, y_r, y_i;

  // Conjugate twiddles e^{+j*2*pi*k/N}, rounded to nearest at elaboration.
  for (genvar k = 0; k < N/2; k++) begin : g_tw
    localparam real ANG = 2.0 * PI_R * real'(k) / real'(N);
    localparam real CR  = $cos(ANG) * real'(1 << FRAC);
    localparam real CI  = $sin(ANG) * real'(1 << FRAC);
    localparam int  CRI = (CR < 0.0) ? -$rtoi(0.5 - CR) : $rtoi(CR + 0.5);
    localparam int  CII = (CI < 0.0) ? -$rtoi(0.5 - CI) : $rtoi(CI + 0.5);
    assign tw_r[k] = TW_WIDTH'(CRI);
    assign tw_i[k] = TW_WIDTH'(CII);
  end

  assign accept    = (state == IDLE) && valid_in && !busy;
  assign cnt_last  = (cnt == '1);
  assign bf_last   = (bf == '1) && (stage == SW'(POW - 1));
  assign load_addr = POW'(bitrev(32'(cnt), POW));

  // Butterfly j of a stage: a = group*2*span + (j mod span), b = a + span.
  always_comb begin
    span_bit = ONE << stage;
    bf_ext   = {1'b0, bf};
    pos      = bf_ext & (span_bit - ONE);
    a_idx    = ((bf_ext & ~(span_bit - ONE)) << 1) | pos;
    b_idx    = a_idx | span_bit;
    k_idx    = JW'(pos << (SW'(POW - 1) - stage));
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)   state_nx = LOAD;
      LOAD:    if (cnt_last) state_nx = CALC;
      CALC:    if (bf_last)  state_nx = DUMP;
      DUMP:    if (cnt_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  ifft_butterfly #(
    .DATA_WIDTH (DATA_WIDTH),
    .TW_WIDTH   (TW_WIDTH)
  ) u_bfly (
    .a_r (mem_r[a_idx]),
    .a_i (mem_i[a_idx]),
    .b_r (mem_r[b_idx]),
    .b_i (mem_i[b_idx]),
    .w_r (tw_r[k_idx]),
    .w_i (tw_i[k_idx]),
    .x_r (x_r),
    .x_i (x_i),
    .y_r (y_r),
    .y_i (y_i)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bf        <= '0;
      stage     <= '0;
      busy      <= 1'b0;
      valid_out <= 1'b0;
      source_r  <= '0;
      source_i  <= '0;
    end else begin
      state <= state_nx;
      // Held through the cycle that presents the last output sample.
      busy      <= (state_nx != IDLE) || (state == DUMP);
      valid_out <= (state == DUMP) && (cnt == '0);
      source_r  <= (state == DUMP) ? mem_r[cnt] : '0;
      source_i  <= (state == DUMP) ? mem_i[cnt] : '0;
      case (state)
        IDLE:       cnt <= accept ? ONE : '0;
        LOAD, DUMP: cnt <= cnt + ONE;
        CALC: begin
          bf <= bf + JW'(1);
          if (bf == '1) stage <= bf_last ? '0 : stage + SW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept || (state == LOAD)) begin
      mem_r[load_addr] <= sink_r;
      mem_i[load_addr] <= sink_i;
    end else if (state == CALC) begin
      mem_r[a_idx] <= x_r;
      mem_i[a_idx] <= x_i;
      mem_r[b_idx] <= y_r;
      mem_i[b_idx] <= y_i;
    end
  end

endmodule

// File: tb/tb_ifft_r2_dit_iter.sv
// Self-checking bench for ifft_r2_dit_iter: directed vector table, random frames
// against an array-based IFFT model, back-to-back and mid-compute reset sequences.
module tb_ifft_r2_dit_iter;

  localparam int DW = 20, POW = 4, TW = 16, N = 1 << POW, FRAC = TW - 2;
  localparam longint SMAX = (longint'(1) <<< (DW - 1)) - 1;
  localparam longint SMIN = -SMAX - 1;
  localparam real PI = 3.141592653589793;
`ifdef IFFT_SCALE_EN
  localparam bit SCALE = 1'b1;
`else
  localparam bit SCALE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, valid_in, busy, valid_out;
  logic signed [DW-1:0] sink_r, sink_i, source_r, source_i;

  always #5 clk = ~clk;

  ifft_r2_dit_iter #(.DATA_WIDTH(DW), .POW(POW), .TW_WIDTH(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .sink_r    (sink_r),
    .sink_i    (sink_i),
    .busy      (busy),
    .valid_out (valid_out),
    .source_r  (source_r),
    .source_i  (source_i)
  );

  typedef struct {
    string  name;
    longint xr[N];
    longint xi[N];
    longint er[N];
    longint ei[N];
    int     tol;
  } vec_t;

  vec_t   vecs[$];
  longint in_r[N], in_i[N], got_r[N], got_i[N], exp_r[N], exp_i[N];
  longint twr[N/2], twi[N/2];
  int     n_pass = 0, n_total = 0;

  task automatic check(input string name, input longint act, input longint want, input longint tol);
    n_total++;
    if ((act - want <= tol) && (want - act <= tol)) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (tol %0d)", name, act, want, tol);
  endtask

  function automatic int brev(input int x);
    int r = 0;
    for (int b = 0; b < POW; b++) if (x[b]) r |= (1 << (POW - 1 - b));
    return r;
  endfunction

  function automatic longint sat(input longint v);
    return (v > SMAX) ? SMAX : ((v < SMIN) ? SMIN : v);
  endfunction

  // Textbook in-place DIT over bit-reversed input, in plain integer arithmetic.
  function automatic void model();
    longint mr[N], mi[N];
    for (int i = 0; i < N; i++) begin
      mr[brev(i)] = in_r[i];
      mi[brev(i)] = in_i[i];
    end
    for (int s = 0; s < POW; s++) begin
      int span = 1 << s;
      for (int a = 0; a < N; a++) begin
        if ((a / span) % 2 == 0) begin
          int     b  = a + span;
          int     k  = (a % span) * (N / (2 * span));
          longint pr = (mr[b] * twr[k] - mi[b] * twi[k]) >>> FRAC;
          longint pi = (mr[b] * twi[k] + mi[b] * twr[k]) >>> FRAC;
          longint ur = mr[a] + pr, ui = mi[a] + pi;
          longint lr = mr[a] - pr, li = mi[a] - pi;
          if (SCALE) begin
            ur = ur >>> 1; ui = ui >>> 1; lr = lr >>> 1; li = li >>> 1;
          end
          mr[a] = sat(ur); mi[a] = sat(ui);
          mr[b] = sat(lr); mi[b] = sat(li);
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      exp_r[i] = mr[i];
      exp_i[i] = mi[i];
    end
  endfunction

  // Starts mid-cycle; feeds in_r/in_i, captures N outputs into got_r/got_i.
  task automatic run_frame(input string tag, input bit stray, input bit early, input bit chain);
    int lat = 0, oi = 0, pulses = 0;
    if (early) begin
      valid_in = 1'b1; sink_r = 20'sd12345; sink_i = -20'sd777;
      @(negedge clk);
      check({tag, " busy_fall"}, longint'(busy), 0, 0);
    end
    valid_in = 1'b1;
    sink_r = DW'(in_r[0]); sink_i = DW'(in_i[0]);
    for (int cyc = 1; cyc <= 70 && oi < N; cyc++) begin
      @(negedge clk);
      if (cyc < N) begin
        valid_in = stray && (cyc == 10);
        sink_r = DW'(in_r[cyc]); sink_i = DW'(in_i[cyc]);
      end else begin
        valid_in = 1'b0; sink_r = '0; sink_i = '0;
      end
      if (cyc == 1) check({tag, " busy_rise"}, longint'(busy), 1, 0);
      if (cyc == 30) check({tag, " src_idle"}, longint'({source_r, source_i}), 0, 0);
      if (valid_out) pulses++;
      if (valid_out && lat == 0) lat = cyc;
      if (lat != 0) begin
        got_r[oi] = source_r; got_i[oi] = source_i;
        oi++;
        if (oi == N) check({tag, " busy_last"}, longint'(busy), 1, 0);
      end
    end
    check({tag, " latency"}, lat, 49, 0);
    check({tag, " vout_pulses"}, pulses, 1, 0);
    if (!chain) begin
      valid_in = 1'b0;
      @(negedge clk);
      check({tag, " busy_fall"}, longint'(busy), 0, 0);
      check({tag, " src_zero"}, longint'({source_r, source_i}), 0, 0);
    end
  endtask

  task automatic cmp_out(input string tag, input int tol);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s x%0d.re", tag, i), got_r[i], exp_r[i], tol);
      check($sformatf("%s x%0d.im", tag, i), got_i[i], exp_i[i], tol);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    real  amp;

    for (int k = 0; k < N/2; k++) begin
      twr[k] = longint'($cos(2.0 * PI * real'(k) / real'(N)) * real'(1 << FRAC));
      twi[k] = longint'($sin(2.0 * PI * real'(k) / real'(N)) * real'(1 << FRAC));
    end

    v.name = "impulse"; v.tol = 0;
    for (int i = 0; i < N; i++) begin
      v.xr[i] = 0; v.xi[i] = 0; v.er[i] = longint'(SCALE ? 1 : 16); v.ei[i] = 0;
    end
    v.xr[0] = 16;
    vecs.push_back(v);

    v.name = "flat"; v.tol = 0;
    for (int i = 0; i < N; i++) begin
      v.xr[i] = 16; v.xi[i] = 0; v.er[i] = 0; v.ei[i] = 0;
    end
    v.er[0] = longint'(SCALE ? 16 : 256);
    vecs.push_back(v);

    v.name = "bin1"; v.tol = SCALE ? 2 : 8;
    amp = SCALE ? 1024.0 : 16384.0;
    for (int i = 0; i < N; i++) begin
      v.xr[i] = 0; v.xi[i] = 0;
      v.er[i] = longint'(amp * $cos(2.0 * PI * real'(i) / real'(N)));
      v.ei[i] = longint'(amp * $sin(2.0 * PI * real'(i) / real'(N)));
    end
    v.xr[1] = 16384;
    vecs.push_back(v);

    v.name = "saturate"; v.tol = 0;
    for (int i = 0; i < N; i++) begin
      v.xr[i] = SMAX; v.xi[i] = 0; v.er[i] = 0; v.ei[i] = 0;
    end
    v.er[0] = SMAX;
    vecs.push_back(v);

    rst = 1'b1; valid_in = 1'b0; sink_r = '0; sink_i = '0;
    repeat (3) @(negedge clk);
    check("reset busy", longint'(busy), 0, 0);
    check("reset valid_out", longint'(valid_out), 0, 0);
    check("reset source", longint'({source_r, source_i}), 0, 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[n]) begin
      in_r = vecs[n].xr; in_i = vecs[n].xi;
      run_frame(vecs[n].name, 1'b0, 1'b0, 1'b0);
      exp_r = vecs[n].er; exp_i = vecs[n].ei;
      cmp_out(vecs[n].name, vecs[n].tol);
    end

    // Frame 0 carries a stray valid_in; frame 1 follows with a pulse in the
    // busy-falling cycle (must be dropped) and a start on the first idle cycle.
    for (int f = 0; f < 3; f++) begin
      int r = (f == 2) ? 200000 : 4000;
      for (int i = 0; i < N; i++) begin
        in_r[i] = longint'($urandom_range(0, 2 * r)) - r;
        in_i[i] = longint'($urandom_range(0, 2 * r)) - r;
      end
      model();
      run_frame($sformatf("rand%0d", f), f == 0, f == 1, f == 0);
      cmp_out($sformatf("rand%0d", f), 0);
    end

    for (int i = 0; i < N; i++) begin
      in_r[i] = longint'($urandom_range(0, 8000)) - 4000;
      in_i[i] = longint'($urandom_range(0, 8000)) - 4000;
    end
    valid_in = 1'b1; sink_r = DW'(in_r[0]); sink_i = DW'(in_i[0]);
    for (int cyc = 1; cyc <= 36; cyc++) begin
      @(negedge clk);
      valid_in = 1'b0;
      sink_r = (cyc < N) ? DW'(in_r[cyc]) : '0;
      sink_i = (cyc < N) ? DW'(in_i[cyc]) : '0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("calc_rst busy", longint'(busy), 0, 0);
    check("calc_rst valid_out", longint'(valid_out), 0, 0);
    check("calc_rst source", longint'({source_r, source_i}), 0, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < N; i++) begin
      in_r[i] = 0; in_i[i] = 0;
      exp_r[i] = longint'(SCALE ? 1 : 16); exp_i[i] = 0;
    end
    in_r[0] = 16;
    run_frame("post_rst", 1'b0, 1'b0, 1'b0);
    cmp_out("post_rst", 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ifft_r2_dit_iter.md
IFFT_R2_DIT_ITER -- requirements
Module: ifft_r2_dit_iter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 20, signed sample width of input and output, sign bit included.
REQ-002 SHALL have parameter POW, default 4, where the point count N = 2**POW.
REQ-003 SHALL have parameter TW_WIDTH, default 16, signed twiddle width with TW_WIDTH-2 fraction bits.
REQ-004 SHALL have port clk, input, 1 bit: the single clock. The block has one clock; reset is synchronous and active-high.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port valid_in, input, 1 bit: pulse coincident with the first sample of a frame.
REQ-007 SHALL have ports sink_r and sink_i, input, DATA_WIDTH bits, signed: frequency-domain sample real and imaginary parts, natural order.
REQ-008 SHALL have port busy, output, 1 bit: high while a frame is being loaded, computed or dumped.
REQ-009 SHALL have port valid_out, output, 1 bit: pulse coincident with the first time-domain output sample.
REQ-010 SHALL have ports source_r and source_i, output, DATA_WIDTH bits, signed: time-domain result, natural order.

Function
REQ-011 SHALL implement an FSM with states IDLE, LOAD, CALC and DUMP:
- IDLE->LOAD on valid_in.
- LOAD->CALC after N samples.
- CALC->DUMP after POW*N/2 butterflies.
- DUMP->IDLE after N outputs.
REQ-012 In IDLE, SHALL write the valid_in sample to address bitrev(0); in LOAD, it SHALL write the next N-1 consecutive samples, unconditionally one per cycle, to address bitrev(count).
REQ-013 In CALC, SHALL perform one in-place radix-2 DIT butterfly per cycle, in stage order 0..POW-1, with span 2**stage.
REQ-014 Each butterfly SHALL compute A' = a + b*W and B' = a - b*W, where W = cos(2*pi*k/N) + j*sin(2*pi*k/N) (conjugate twiddle) and k = (index mod span) * N/(2*span).
REQ-015 The complex product b*W SHALL use full-precision multiplies, then an arithmetic right shift of TW_WIDTH-2; the twiddle for 1.0 is 2**(TW_WIDTH-2).
REQ-016 In DUMP, SHALL output memory[0..N-1] one per registered cycle; valid_out SHALL be high only with sample 0.
REQ-017 SHALL drive source_r and source_i to 0 outside DUMP output cycles.
REQ-018 Latency: valid_out SHALL rise exactly N + POW*N/2 + 1 cycles after the valid_in cycle (49 for POW=4).
REQ-019 busy SHALL rise the cycle after valid_in and fall the cycle after the last output sample.
REQ-020 valid_in while busy is high SHALL be ignored; the frame in progress is unaffected.
REQ-021 valid_in in the same cycle that busy falls SHALL NOT be accepted; valid_in SHALL be accepted on the first cycle that busy is low.

Reset
REQ-022 rst SHALL force IDLE, busy=0, valid_out=0 and source_r=source_i=0 on the next clk edge, from any state, including mid-CALC.
REQ-023 Data memory SHALL NOT be reset; a frame loaded after reset SHALL be computed correctly.

Configuration
REQ-024 With IFFT_SCALE_EN defined, each butterfly output SHALL be arithmetically shifted right by 1 before write-back, giving a total 1/N scale.
REQ-025 Without IFFT_SCALE_EN, there SHALL be no shift, and each write-back SHALL saturate to the signed DATA_WIDTH range.

Structure
REQ-026 Package fft_pkg SHALL hold the FSM state enum, the twiddle fraction-bit constant and the bitrev function.
REQ-027 The twiddle table SHALL be generated from POW and TW_WIDTH at elaboration.
REQ-028 The complex multiply, add/subtract and scale/saturate SHALL reside in the combinational sub-module ifft_butterfly.

Verification (POW=4, DATA_WIDTH=20, TW_WIDTH=16, IFFT_SCALE_EN defined unless noted)
REQ-029 Impulse: X[0]=16+0j, others 0 -> all 16 outputs equal 1+0j; valid_out 49 cycles after valid_in.
REQ-030 Flat spectrum: all X[k]=16+0j -> x[0]=16+0j, x[1..15]=0+0j.
REQ-031 Single bin: X[1]=16384+0j -> x[n] is approximately 1024*e^{j*2*pi*n/16} within ±2 LSB; x[4] is approximately 0+1024j and x[8] is approximately -1024+0j.
REQ-032 Back-to-back: a second valid_in 10 cycles after the first -> ignored, first frame output exact; a valid_in on the first cycle busy is low -> accepted.
REQ-033 Reset: rst pulsed at cycle 20 of CALC -> next cycle busy=0, valid_out=0, source=0; a following impulse frame gives all outputs 1+0j.
REQ-034 IFFT_SCALE_EN undefined: impulse X[0]=16 -> all outputs 16+0j; X[0]=2**19-1 with all other bins equal -> outputs saturate at 2**19-1 with no wrap.
